// File: rtl/alu_pkg.sv
// Shared ALU definitions: default geometry of the add/sub pipeline, operation
// encoding and the geometry check used at elaboration.
package alu_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Geometry is legal when every segment gets the same whole number of bits.
  function automatic bit geometry_ok(int width, int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_sub_if.sv
// Operand/result handshake bundle for the pipelined add/sub unit.
interface pipelined_adder_sub_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, y, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, y, c_out, ovf
  );

endinterface

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple of full-adder cells; also exposes the carry into
// its top bit so the final segment can derive signed overflow.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry[SEG];
  assign c_msb_in = carry[SEG-1];

endmodule

// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit add/subtract split into STAGES registered ripple segments, with
// valid/ready handshakes and full backpressure on both sides.
module pipelined_adder_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_adder_sub_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_adder_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES:0]   en;
  logic [STAGES:0]   v_chain;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_q, carry_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  sum_src [STAGES];
  logic [STAGES-1:0] cin_src;
  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_cout;
  logic [STAGES-1:0] seg_cmsb;
  logic              sub_mode;

  assign sub_mode = (op_e'(bus.sub) == OP_SUB);

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    en         = '0;
    en[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !v_q[k] | en[k + 1];
    end
  end

  always_comb begin
    a_src[0]   = bus.a;
    b_src[0]   = sub_mode ? ~bus.b : bus.b;
    sum_src[0] = '0;
    cin_src    = '0;
    cin_src[0] = bus.c_in ^ sub_mode;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k - 1];
      b_src[k]   = b_q[k - 1];
      sum_src[k] = sum_q[k - 1];
      cin_src[k] = carry_q[k - 1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(
      .SEG (SEG)
    ) u_segment (
      .a        (a_src[k][k*SEG +: SEG]),
      .b        (b_src[k][k*SEG +: SEG]),
      .cin      (cin_src[k]),
      .sum      (seg_sum[k]),
      .cout     (seg_cout[k]),
      .c_msb_in (seg_cmsb[k])
    );
  end

  assign v_chain = {v_q, bus.in_valid};

  always_comb begin
    v_d     = v_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      if (en[k]) begin
        v_d[k]                  = v_chain[k];
        a_d[k]                  = a_src[k];
        b_d[k]                  = b_src[k];
        sum_d[k]                = sum_src[k];
        sum_d[k][k*SEG +: SEG]  = seg_sum[k];
        carry_d[k]              = seg_cout[k];
      end
    end
    if (en[STAGES-1]) begin
      ovf_d = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.y         = sum_q[STAGES-1];
  assign bus.c_out     = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule
